imm_ext_arbiter: RTL and testbench

IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

---
 rtl/imm_ext_pkg.sv | 16 +
 rtl/imm_field_ext.sv | 58 +++++
 rtl/imm_ext_arbiter.sv | 105 ++++++++++
 tb/tb_imm_ext_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension arbiter: format codes and the
// output-register state type.
package imm_ext_pkg;

  localparam logic [2:0] FMT_D  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_CB = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_IW = 3'd4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/imm_field_ext.sv
// Combinational immediate extractor: maps (instr, fmt) to an extended immediate.
// Optional macro IMM_BRANCH_SHIFT_EN turns CB/B results into byte offsets.
module imm_field_ext
  import imm_ext_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [2:0]         fmt,
  output logic [DATA_W-1:0]  imm,
  output logic               err
);

  logic [DATA_W-1:0] d_ext;
  logic [DATA_W-1:0] i_ext;
  logic [DATA_W-1:0] cb_ext;
  logic [DATA_W-1:0] b_ext;
  logic [DATA_W-1:0] iw_ext;
  logic [DATA_W-1:0] cb_ofs;
  logic [DATA_W-1:0] b_ofs;
  logic [5:0]        iw_shamt;
  logic              unused_instr;

  assign d_ext  = {{(DATA_W-9){instr[20]}}, instr[20:12]};
  assign i_ext  = {{(DATA_W-12){1'b0}}, instr[21:10]};
  assign cb_ext = {{(DATA_W-19){instr[23]}}, instr[23:5]};
  assign b_ext  = {{(DATA_W-26){instr[25]}}, instr[25:0]};

  // IW places the 16-bit chunk at halfword lane instr[22:21].
  assign iw_shamt = {instr[22:21], 4'b0000};
  assign iw_ext   = {{(DATA_W-16){1'b0}}, instr[20:5]} << iw_shamt;

`ifdef IMM_BRANCH_SHIFT_EN
  assign cb_ofs = cb_ext << 2;
  assign b_ofs  = b_ext << 2;
`else
  assign cb_ofs = cb_ext;
  assign b_ofs  = b_ext;
`endif

  // Upper instruction bits belong to no immediate field.
  assign unused_instr = ^instr;

  always_comb begin
    imm = '0;
    err = 1'b0;
    case (fmt)
      FMT_D:   imm = d_ext;
      FMT_I:   imm = i_ext;
      FMT_CB:  imm = cb_ofs;
      FMT_B:   imm = b_ofs;
      FMT_IW:  imm = iw_ext;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Two-requester round-robin arbiter feeding a single immediate extractor with a
// one-entry output register. Optional macro: IMM_BRANCH_SHIFT_EN (see imm_field_ext).
module imm_ext_arbiter
  import imm_ext_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [INSTR_W-1:0] req_instr0,
  input  logic [INSTR_W-1:0] req_instr1,
  input  logic [2:0]         req_fmt0,
  input  logic [2:0]         req_fmt1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_imm,
  output logic               out_id,
  output logic               out_err
);

  state_t             state;
  state_t             state_next;
  logic               last_id;
  logic               can_grant;
  logic               grant;
  logic               grant_id;
  logic [INSTR_W-1:0] sel_instr;
  logic [2:0]         sel_fmt;
  logic [DATA_W-1:0]  ext_imm;
  logic               ext_err;

  // Round-robin: under contention the requester not granted last wins.
  always_comb begin
    can_grant = rst_n && ((state == EMPTY) || out_ready);
    case (req_valid)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_id;
      default: grant_id = 1'b0;
    endcase
    grant     = can_grant && (req_valid != 2'b00);
    req_ready = 2'b00;
    if (grant) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign sel_instr = grant_id ? req_instr1 : req_instr0;
  assign sel_fmt   = grant_id ? req_fmt1 : req_fmt0;

  imm_field_ext #(
    .DATA_W (DATA_W),
    .INSTR_W(INSTR_W)
  ) u_field_ext (
    .instr(sel_instr),
    .fmt  (sel_fmt),
    .imm  (ext_imm),
    .err  (ext_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    out_valid  = (state == FULL);
    case (state)
      EMPTY: begin
        if (grant) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (grant) begin
          state_next = FULL;
        end else if (out_ready) begin
          state_next = EMPTY;
        end
      end
    endcase
  end

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_imm <= '0;
      out_id  <= 1'b0;
      out_err <= 1'b0;
      last_id <= 1'b1;
    end else if (grant) begin
      out_imm <= ext_imm;
      out_id  <= grant_id;
      out_err <= ext_err;
      last_id <= grant_id;
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Self-checking bench for imm_ext_arbiter: vector table, directed multi-cycle
// sequences and randomized traffic against an arithmetic reference model.
module tb_imm_ext_arbiter;
  import imm_ext_pkg::*;

  localparam int DATA_W  = 64;
  localparam int INSTR_W = 32;

`ifdef IMM_BRANCH_SHIFT_EN
  localparam longint BR_SCALE = 4;
`else
  localparam longint BR_SCALE = 1;
`endif

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [31:0]       req_instr0;
  logic [31:0]       req_instr1;
  logic [2:0]        req_fmt0;
  logic [2:0]        req_fmt1;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_imm;
  logic              out_id;
  logic              out_err;

  imm_ext_arbiter #(
    .DATA_W (DATA_W),
    .INSTR_W(INSTR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_instr0(req_instr0),
    .req_instr1(req_instr1),
    .req_fmt0  (req_fmt0),
    .req_fmt1  (req_fmt1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_id    (out_id),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          m_full;
  logic [63:0] m_imm;
  bit          m_id;
  bit          m_err;
  bit          m_last;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int   rr_exp[4] = '{0, 1, 0, 1};

  function automatic logic [63:0] br(input logic [63:0] v);
    return v * 64'(BR_SCALE);
  endfunction

  // Reference extension from field arithmetic: {err, imm}.
  function automatic logic [64:0] ref_ext(input logic [31:0] instr, input logic [2:0] fmt);
    longint u;
    longint v;
    u = longint'(instr);
    case (fmt)
      3'd0: begin
        v = (u >> 12) % 512;
        if (v >= 256) v = v - 512;
      end
      3'd1: v = (u >> 10) % 4096;
      3'd2: begin
        v = (u >> 5) % 524288;
        if (v >= 262144) v = v - 524288;
        v = v * BR_SCALE;
      end
      3'd3: begin
        v = u % 67108864;
        if (v >= 33554432) v = v - 67108864;
        v = v * BR_SCALE;
      end
      3'd4: v = ((u >> 5) % 65536) * (longint'(1) << (16 * ((u >> 21) % 4)));
      default: return {1'b1, 64'd0};
    endcase
    return {1'b0, 64'(v)};
  endfunction

  function automatic logic [1:0] exp_ready();
    if (!rst_n) return 2'b00;
    if (m_full && !out_ready) return 2'b00;
    case (req_valid)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return m_last ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    m_full = 1'b0;
    m_imm  = '0;
    m_id   = 1'b0;
    m_err  = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [2:0] f0,
                       input logic [31:0] i1, input logic [2:0] f1, input logic ordy);
    req_valid  = v;
    req_instr0 = i0;
    req_fmt0   = f0;
    req_instr1 = i1;
    req_fmt1   = f1;
    out_ready  = ordy;
  endtask

  task automatic check_output();
    #1;
    check("req_ready", 64'(req_ready), 64'(exp_ready()));
    check("out_valid", 64'(out_valid), 64'(m_full));
    if (m_full) begin
      check("out_imm", out_imm, m_imm);
      check("out_id", 64'(out_id), 64'(m_id));
      check("out_err", 64'(out_err), 64'(m_err));
    end
  endtask

  task automatic step();
    logic [1:0]  g;
    logic [64:0] r;
    g = exp_ready();
    @(posedge clk);
    if (g != 2'b00) begin
      r      = ref_ext(g[1] ? req_instr1 : req_instr0, g[1] ? req_fmt1 : req_fmt0);
      m_full = 1'b1;
      m_imm  = r[63:0];
      m_err  = r[64];
      m_id   = g[1];
      m_last = g[1];
    end else if (out_ready) begin
      m_full = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [1:0] v, input logic [31:0] i0, input logic [2:0] f0,
                                input logic [31:0] i1, input logic [2:0] f1, input logic ordy);
    drive(v, i0, f0, i1, f1, ordy);
    check_output();
    step();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] time limit exceeded");
  end

  initial begin
    vecs.push_back(vec_t'{32'h001FF000, FMT_D,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    vecs.push_back(vec_t'{32'h000FF000, FMT_D,  64'h0000_0000_0000_00FF, 1'b0});
    vecs.push_back(vec_t'{32'h803FFC01, FMT_I,  64'h0000_0000_0000_0FFF, 1'b0});
    vecs.push_back(vec_t'{32'h00FFFFE0, FMT_CB, br(64'hFFFF_FFFF_FFFF_FFFF), 1'b0});
    vecs.push_back(vec_t'{32'h00000020, FMT_CB, br(64'h0000_0000_0000_0001), 1'b0});
    vecs.push_back(vec_t'{32'h02000000, FMT_B,  br(64'hFFFF_FFFF_FE00_0000), 1'b0});
    vecs.push_back(vec_t'{32'h01FFFFFF, FMT_B,  br(64'h0000_0000_01FF_FFFF), 1'b0});
    vecs.push_back(vec_t'{32'h00424680, FMT_IW, 64'h0000_1234_0000_0000, 1'b0});
    vecs.push_back(vec_t'{32'h007FFFE0, FMT_IW, 64'hFFFF_0000_0000_0000, 1'b0});
    vecs.push_back(vec_t'{32'hFFFFFFFF, 3'd6,   64'h0, 1'b1});
    vecs.push_back(vec_t'{32'h12345678, 3'd5,   64'h0, 1'b1});
    vecs.push_back(vec_t'{32'hFFFFFFFF, 3'd7,   64'h0, 1'b1});

    // Reset with requests pending: nothing may be accepted.
    rst_n = 1'b0;
    model_reset();
    drive(2'b11, 32'hFFFFFFFF, FMT_D, 32'hFFFFFFFF, FMT_D, 1'b1);
    repeat (2) @(negedge clk);
    check_output();
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_imm", out_imm, 64'd0);
    check("rst_id", 64'(out_id), 64'd0);
    check("rst_err", 64'(out_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) apply_stimulus(2'b00, 32'h0, FMT_D, 32'h0, FMT_D, 1'b1);
    check("idle_valid", 64'(out_valid), 64'd0);
    check("idle_imm", out_imm, 64'd0);

    // Contention: alternating grants starting with requester 0.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(2'b11, 32'h001FF000, FMT_D, 32'h00000400, FMT_I, 1'b1);
      check($sformatf("rr_order%0d", i), 64'(out_id), 64'(rr_exp[i]));
    end
    apply_stimulus(2'b00, 32'h0, FMT_D, 32'h0, FMT_D, 1'b1);

    // Format table, alternating ports, back-to-back.
    for (int i = 0; i < vecs.size(); i++) begin
      if (i % 2 == 0)
        apply_stimulus(2'b01, vecs[i].instr, vecs[i].fmt, $urandom, 3'($urandom_range(0, 7)), 1'b1);
      else
        apply_stimulus(2'b10, $urandom, 3'($urandom_range(0, 7)), vecs[i].instr, vecs[i].fmt, 1'b1);
      check($sformatf("vec%0d_imm", i), out_imm, vecs[i].imm);
      check($sformatf("vec%0d_err", i), 64'(out_err), 64'(vecs[i].err));
      check($sformatf("vec%0d_id", i), 64'(out_id), 64'(i % 2));
    end

    // Lone requester is granted every cycle.
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 32'h0, FMT_D, 32'h00001000 * i, FMT_D, 1'b1);
      check_output();
      check("solo_ready", 64'(req_ready), 64'b10);
      step();
    end
    apply_stimulus(2'b00, 32'h0, FMT_D, 32'h0, FMT_D, 1'b1);

    // Backpressure: result holds, then the pending request goes through at once.
    apply_stimulus(2'b01, 32'h000FF000, FMT_D, 32'h0, FMT_D, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 32'h003FFC00, FMT_I, 32'h0, FMT_D, 1'b0);
      check_output();
      check("bp_ready", 64'(req_ready), 64'd0);
      step();
      check("bp_hold", out_imm, 64'h0000_0000_0000_00FF);
      check("bp_valid", 64'(out_valid), 64'd1);
    end
    drive(2'b01, 32'h003FFC00, FMT_I, 32'h0, FMT_D, 1'b1);
    check_output();
    check("bp_regrant", 64'(req_ready), 64'b01);
    step();
    check("bp_new", out_imm, 64'h0000_0000_0000_0FFF);
    apply_stimulus(2'b00, 32'h0, FMT_D, 32'h0, FMT_D, 1'b1);

    // Reset while a result is held: it must vanish and the pointer restart.
    apply_stimulus(2'b10, 32'h0, FMT_D, 32'h02000000, FMT_B, 1'b0);
    drive(2'b11, 32'h0, FMT_D, 32'h0, FMT_D, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    drive(2'b00, 32'h0, FMT_D, 32'h0, FMT_D, 1'b1);
    rst_n = 1'b1;
    repeat (2) apply_stimulus(2'b00, 32'h0, FMT_D, 32'h0, FMT_D, 1'b1);
    check("mr_after", 64'(out_valid), 64'd0);
    apply_stimulus(2'b11, 32'h001FF000, FMT_D, 32'h00000400, FMT_I, 1'b1);
    check("mr_tie_id", 64'(out_id), 64'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      apply_stimulus(2'($urandom_range(0, 3)), $urandom, 3'($urandom_range(0, 7)),
                     $urandom, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
    end
    repeat (2) apply_stimulus(2'b00, 32'h0, FMT_D, 32'h0, FMT_D, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
